// File: rtl/shift_frame_sequencer_pkg.sv
// Shared definitions for the shift frame sequencer.
//   - seq_state_e   : FSM state encodings (IDLE=0, SHIFT=1, GAP=2)
//   - DEFAULT_WIDTH : default word length in bits
//   - DEFAULT_GAP   : default idle cycles after each frame
//   - cnt_width()   : counter width helper, never narrower than one bit
package shift_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 1;

    // Width needed to hold the value n-1.
    // Clamped to one bit so that a zero-range counter still has a legal declaration.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register. Shifts left (MSB first) with zero fill.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the register
//   load  : capture d on the next posedge (has priority over shift)
//   shift : shift left by one bit on the next posedge
//   d     : parallel word to load
//   msb   : current most significant bit
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_r;

    // Shift register storage: load wins over shift; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= d;
        end else if (shift) begin
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign msb = shreg_r[WIDTH-1];

endmodule

// File: rtl/shift_frame_sequencer.sv
// Frame sequencer for a PISO shift register.
// Accepts one word per valid/ready handshake and shifts it out MSB first, one bit
// per clock. Each frame is marked with frame_start on its first bit and a
// one-cycle done pulse after its last bit, and is followed by GAP idle cycles.
//   clk         : clock
//   rst         : asynchronous active-high reset; all outputs are 0 while it is high
//   in_data     : parallel word, sampled only on the accepting edge
//   in_valid    : producer has a word
//   in_ready    : sequencer accepts a word (IDLE only)
//   ser_out     : current serial bit
//   ser_en      : ser_out is valid
//   frame_start : first (MSB) bit of a frame
//   done        : one-cycle pulse after the last bit
//   busy        : in SHIFT or GAP
// Every output is a flop or a flop bit, so there is no input-to-output path.
module shift_frame_sequencer
    import shift_frame_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int GCW = cnt_width(GAP);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1'b1);
    localparam logic [BCW-1:0] BIT_ZERO = BCW'(1'b0);
    // Wraps harmlessly when GAP is 0; the GAP state is never entered then.
    localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP - 1);
    localparam logic [GCW-1:0] GAP_ONE  = GCW'(1'b1);
    localparam logic [GCW-1:0] GAP_ZERO = GCW'(1'b0);

    seq_state_e     state_r;
    logic [BCW-1:0] bit_cnt_r;
    logic [GCW-1:0] gap_cnt_r;
    logic           done_r;
    logic           ser_en_r;
    logic           busy_r;
    logic           frame_start_r;
    logic           in_ready_r;

    logic           load_s;
    logic           shift_s;
    logic           msb_s;

    // The handshake uses the registered in_ready, so acceptance is never
    // possible while rst is high or outside IDLE.
    assign load_s  = (state_r == ST_IDLE) && in_valid && in_ready_r;
    assign shift_s = (state_r == ST_SHIFT);

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .d     (in_data),
        .msb   (msb_s)
    );

    // FSM with counters. The outputs are registered here from the next-state value,
    // so each flag lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= BIT_ZERO;
            gap_cnt_r     <= GAP_ZERO;
            done_r        <= 1'b0;
            ser_en_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_start_r <= 1'b0;
            in_ready_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (load_s) begin
                        state_r       <= ST_SHIFT;
                        bit_cnt_r     <= BIT_LAST;
                        ser_en_r      <= 1'b1;
                        busy_r        <= 1'b1;
                        frame_start_r <= 1'b1;
                        in_ready_r    <= 1'b0;
                    end else begin
                        ser_en_r      <= 1'b0;
                        busy_r        <= 1'b0;
                        frame_start_r <= 1'b0;
                        in_ready_r    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    frame_start_r <= 1'b0;
                    if (bit_cnt_r == BIT_ZERO) begin
                        done_r    <= 1'b1;
                        ser_en_r  <= 1'b0;
                        bit_cnt_r <= BIT_ZERO;
                        if (GAP > 0) begin
                            state_r    <= ST_GAP;
                            gap_cnt_r  <= GAP_LOAD;
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - BIT_ONE;
                        done_r    <= 1'b0;
                        ser_en_r  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    done_r        <= 1'b0;
                    ser_en_r      <= 1'b0;
                    frame_start_r <= 1'b0;
                    if (gap_cnt_r == GAP_ZERO) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                    end else begin
                        gap_cnt_r  <= gap_cnt_r - GAP_ONE;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    bit_cnt_r     <= BIT_ZERO;
                    gap_cnt_r     <= GAP_ZERO;
                    done_r        <= 1'b0;
                    ser_en_r      <= 1'b0;
                    busy_r        <= 1'b0;
                    frame_start_r <= 1'b0;
                    in_ready_r    <= 1'b0;
                end
            endcase
        end
    end

    // The shift register already reads as 0 outside a frame: it is cleared by
    // reset and emptied by the zero-fill shifts of the previous frame.
    assign ser_out     = msb_s;
    assign ser_en      = ser_en_r;
    assign frame_start = frame_start_r;
    assign done        = done_r;
    assign busy        = busy_r;
    assign in_ready    = in_ready_r;

endmodule
